// File: rtl/dac_spi_tx_pkg.sv
// Shared types, frame geometry and small helpers for the DAC SPI transmitter.
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } dac_tx_state_t;

  localparam int FRAME_BITS      = 16;
  localparam int DAC_DATA_BITS   = 12;
  localparam int DAC_CFG_BITS    = FRAME_BITS - DAC_DATA_BITS;
  localparam int BIT_CNT_W       = $clog2(FRAME_BITS);
  localparam logic [DAC_CFG_BITS-1:0] DAC_CFG_DEFAULT = 4'b0011;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Upper DAC_DATA_BITS of the sample, config nibble on top; plain truncation.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [DAC_CFG_BITS-1:0] cfg,
    input logic [FRAME_BITS-1:0]   sample
  );
    return {cfg, sample[FRAME_BITS-1 -: DAC_DATA_BITS]};
  endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// Sample handshake between the effect chain (master) and the DAC transmitter (slave).
interface dac_spi_tx_if;
  import dac_pkg::*;

  logic [FRAME_BITS-1:0] sample_in;
  logic                  sample_valid;
  logic                  sample_ready;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/dac_spi_tx_sclk_divider.sv
// SCLK phase timer: counts CLK_DIV cycles per half period while enabled and
// flags the last cycle of the low phase (rise_en) and of the high phase (fall_en).
module sclk_divider
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk_25mhz,
  input  logic reset,
  input  logic i_en,
  output logic o_rise_en,
  output logic o_fall_en
);

  localparam int            CW   = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_phase_high;
  logic          w_last;

  assign w_last    = i_en && (r_cnt == LAST);
  assign o_rise_en = w_last && !r_phase_high;
  assign o_fall_en = w_last &&  r_phase_high;

  // Half-period counter; restarts in the low phase whenever shifting is not active.
  always_ff @(posedge clk_25mhz) begin
    if (reset || !i_en) begin
      r_cnt        <= '0;
      r_phase_high <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt        <= '0;
      r_phase_high <= ~r_phase_high;
    end else begin
      r_cnt        <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Audio sample to 16-bit DAC frame, shifted out MSB-first on a mode-0 SPI link.
//
// state | meaning
// IDLE  | waiting for a sample; sample_ready high once out of reset
// SHIFT | frame on the wire, active_out high, 16 bits of 2*CLK_DIV cycles each
// GAP   | active_out low for GAP_CYCLES before the next sample is accepted
module dac_spi_tx
  import dac_pkg::*;
#(
  parameter int                      CLK_DIV    = 2,
  parameter logic [DAC_CFG_BITS-1:0] CFG_BITS   = DAC_CFG_DEFAULT,
  parameter int                      GAP_CYCLES = 2
) (
  input  logic         clk_25mhz,
  input  logic         reset,
  dac_spi_tx_if.slave  s_if,
  output logic         sclk_out,
  output logic         mosi_out,
  output logic         active_out,
  output logic         frame_done
);

  localparam int            GW       = cnt_width(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  dac_tx_state_t          r_state;
  logic [FRAME_BITS-1:0]  r_shift;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [GW-1:0]          r_gap_cnt;
  logic                   r_ready;
  logic                   r_sclk;
  logic                   r_mosi;
  logic                   r_active;
  logic                   r_done;

  logic                   w_shift_en;
  logic                   w_rise_en;
  logic                   w_fall_en;
  logic [FRAME_BITS-1:0]  w_frame;

  assign w_shift_en = (r_state == SHIFT);
  assign w_frame    = build_frame(CFG_BITS, s_if.sample_in);

  sclk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_divider (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .i_en      (w_shift_en),
    .o_rise_en (w_rise_en),
    .o_fall_en (w_fall_en)
  );

  // Transmit sequencer; every output is a register so the SPI pins are glitch-free.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_ready   <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // ready comes up one edge after reset; a handshake needs it already high
          if (!r_ready) begin
            r_ready <= 1'b1;
          end else if (s_if.sample_valid) begin
            r_state   <= SHIFT;
            r_shift   <= w_frame;
            r_mosi    <= w_frame[FRAME_BITS-1];
            r_bit_cnt <= BIT_CNT_W'(FRAME_BITS - 1);
            r_active  <= 1'b1;
            r_sclk    <= 1'b0;
            r_ready   <= 1'b0;
          end
        end

        SHIFT: begin
          if (w_rise_en) begin
            r_sclk <= 1'b1;
          end else if (w_fall_en) begin
            r_sclk <= 1'b0;
            if (r_bit_cnt == '0) begin
              r_state   <= GAP;
              r_active  <= 1'b0;
              r_mosi    <= 1'b0;
              r_shift   <= '0;
              r_done    <= 1'b1;
              r_gap_cnt <= GAP_LOAD;
            end else begin
              // next bit goes out on the same edge that drops SCLK
              r_bit_cnt <= r_bit_cnt - BIT_CNT_W'(1);
              r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
              r_mosi    <= r_shift[FRAME_BITS-2];
            end
          end
        end

        GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign s_if.sample_ready = r_ready;
  assign sclk_out          = r_sclk;
  assign mosi_out          = r_mosi;
  assign active_out        = r_active;
  assign frame_done        = r_done;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: one instance at default parameters, one at CLK_DIV=1 / GAP_CYCLES=3.
module tb_dac_spi_tx;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dac_spi_tx_if if0 ();
  dac_spi_tx_if if1 ();

  logic [15:0] sin [2];
  logic        vld [2];
  logic        sclk0, mosi0, act0, done0;
  logic        sclk1, mosi1, act1, done1;

  assign if0.sample_in    = sin[0];
  assign if0.sample_valid = vld[0];
  assign if1.sample_in    = sin[1];
  assign if1.sample_valid = vld[1];

  dac_spi_tx u_dut0 (
    .clk_25mhz  (clk),
    .reset      (reset),
    .s_if       (if0.slave),
    .sclk_out   (sclk0),
    .mosi_out   (mosi0),
    .active_out (act0),
    .frame_done (done0)
  );

  dac_spi_tx #(
    .CLK_DIV    (1),
    .GAP_CYCLES (3)
  ) u_dut1 (
    .clk_25mhz  (clk),
    .reset      (reset),
    .s_if       (if1.slave),
    .sclk_out   (sclk1),
    .mosi_out   (mosi1),
    .active_out (act1),
    .frame_done (done1)
  );

  logic [1:0] m_sclk, m_mosi, m_act, m_done, m_rdy, m_vld;
  assign m_sclk = {sclk1, sclk0};
  assign m_mosi = {mosi1, mosi0};
  assign m_act  = {act1, act0};
  assign m_done = {done1, done0};
  assign m_rdy  = {if1.sample_ready, if0.sample_ready};
  assign m_vld  = {vld[1], vld[0]};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Wire-level observations per instance, taken mid-cycle on the falling clock edge.
  logic [15:0] fr   [2][64];
  int          nb   [2][64];
  int          hi   [2][64];
  int          lo   [2][64];
  int          hsc  [2][64];
  int          nfr [2], nlo [2], nhs [2];
  int          cur_n [2], hi_run [2], lo_run [2];
  logic [15:0] cur [2];
  int          done_cnt [2], done_err [2], stab_err [2], idle_err [2], aborts [2];
  int          tog_err;
  logic [1:0]  p_sclk = '0, p_mosi = '0, p_act = '0;

  initial begin
    for (int d = 0; d < 2; d++) begin
      nfr[d] = 0; nlo[d] = 0; nhs[d] = 0; cur_n[d] = 0; hi_run[d] = 0; lo_run[d] = 0;
      cur[d] = '0; done_cnt[d] = 0; done_err[d] = 0; stab_err[d] = 0; idle_err[d] = 0;
      aborts[d] = 0;
    end
    tog_err = 0;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (m_vld[d] && m_rdy[d]) begin
        if (nhs[d] < 64) hsc[d][nhs[d]] = cyc;
        nhs[d]++;
      end
      if (m_done[d]) begin
        done_cnt[d]++;
        if (!(p_act[d] && !m_act[d])) done_err[d]++;
      end
      if (!m_act[d] && m_sclk[d]) idle_err[d]++;
      if (m_act[d]) begin
        hi_run[d]++;
        if (m_sclk[d] && !p_sclk[d]) begin
          cur[d] = {cur[d][14:0], m_mosi[d]};
          cur_n[d]++;
        end
        if (p_act[d] && !(p_sclk[d] && !m_sclk[d]) && (m_mosi[d] !== p_mosi[d])) stab_err[d]++;
        if (d == 1 && p_act[d] && (m_sclk[d] === p_sclk[d])) tog_err++;
        if (!p_act[d]) begin
          if (nlo[d] < 64) lo[d][nlo[d]] = lo_run[d];
          nlo[d]++;
        end
        lo_run[d] = 0;
      end else begin
        lo_run[d]++;
        if (p_act[d]) begin
          if (m_done[d]) begin
            if (nfr[d] < 64) begin
              fr[d][nfr[d]] = cur[d];
              nb[d][nfr[d]] = cur_n[d];
              hi[d][nfr[d]] = hi_run[d];
            end
            nfr[d]++;
          end else begin
            aborts[d]++;
          end
          hi_run[d] = 0;
          cur[d]    = '0;
          cur_n[d]  = 0;
        end
      end
    end
    p_sclk = m_sclk;
    p_mosi = m_mosi;
    p_act  = m_act;
  end

  // Expected frame: config nibble 3 above the top twelve sample bits.
  function automatic logic [15:0] model(input logic [15:0] s);
    return 16'(32'h3000 + (32'(s) >> 4));
  endfunction

  function automatic int div_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int gap_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a sample, wait for its handshake edge, then check the frame start timing.
  task automatic hs(input int d, input logic [15:0] s, input bit keep);
    int          start;
    bit          got;
    logic [15:0] f;
    f        = model(s);
    sin[d]   = s;
    vld[d]   = 1'b1;
    start    = nhs[d];
    got      = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(posedge clk); #1;
      if (nhs[d] != start) got = 1'b1;
    end
    check("hs_seen", 32'(got), 32'd1);
    if (!keep) vld[d] = 1'b0;
    check("act_first", 32'(m_act[d]), 32'd1);
    check("mosi_first", 32'(m_mosi[d]), 32'(f[15]));
    check("rdy_drop", 32'(m_rdy[d]), 32'd0);
    for (int k = 1; k <= div_of(d); k++) begin
      @(posedge clk); #1;
      check("sclk_first_rise", 32'(m_sclk[d]), (k == div_of(d)) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic wait_frames(input int d, input int n);
    for (int k = 0; k < 800 && nfr[d] < n; k++) begin
      @(posedge clk); #1;
    end
    check("frame_timeout", 32'(nfr[d] >= n), 32'd1);
  endtask

  task automatic check_reset_outputs(input int d);
    check("rst_ready", 32'(m_rdy[d]), 32'd0);
    check("rst_sclk",  32'(m_sclk[d]), 32'd0);
    check("rst_mosi",  32'(m_mosi[d]), 32'd0);
    check("rst_act",   32'(m_act[d]), 32'd0);
    check("rst_done",  32'(m_done[d]), 32'd0);
  endtask

  initial begin
    int          base, hb, lb, dc, ab, hsn;
    logic [15:0] r;
    logic [15:0] smp [5];
    bit          hit;

    sin[0] = '0; sin[1] = '0; vld[0] = 1'b0; vld[1] = 1'b0;

    // reset values and ready release
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst0", 32'(m_rdy[0]), 32'd1);
    check("ready_after_rst1", 32'(m_rdy[1]), 32'd1);

    // single frame at defaults
    base = nfr[0]; dc = done_cnt[0];
    hs(0, 16'hABCD, 1'b0);
    wait_frames(0, base + 1);
    check("abcd_frame", 32'(fr[0][base]), 32'(model(16'hABCD)));
    check("abcd_bits",  32'(nb[0][base]), 32'd16);
    check("abcd_active", 32'(hi[0][base]), 32'd64);
    check("abcd_done",  32'(done_cnt[0] - dc), 32'd1);
    repeat (5) @(posedge clk); #1;

    // back-to-back with valid held: FFFF then 000F
    base = nfr[0]; hb = nhs[0]; lb = nlo[0];
    hs(0, 16'hFFFF, 1'b1);
    hs(0, 16'h000F, 1'b1);
    vld[0] = 1'b0;
    wait_frames(0, base + 2);
    check("ffff_frame", 32'(fr[0][base]), 32'(model(16'hFFFF)));
    check("000f_frame", 32'(fr[0][base + 1]), 32'(model(16'h000F)));
    check("b2b_gap", 32'(lo[0][lb + 1]), 32'd3);
    check("b2b_period", 32'(hsc[0][hb + 1] - hsc[0][hb]), 32'd67);
    repeat (5) @(posedge clk); #1;

    // CLK_DIV=1 instance
    base = nfr[1];
    hs(1, 16'h8000, 1'b0);
    wait_frames(1, base + 1);
    check("div1_frame",  32'(fr[1][base]), 32'(model(16'h8000)));
    check("div1_active", 32'(hi[1][base]), 32'd32);
    check("div1_toggle", 32'(tog_err), 32'd0);
    repeat (5) @(posedge clk); #1;

    // random streams on both instances against the frame/timing model
    for (int d = 0; d < 2; d++) begin
      base = nfr[d]; hb = nhs[d]; lb = nlo[d];
      for (int i = 0; i < 5; i++) begin
        smp[i] = 16'($urandom);
        hs(d, smp[i], 1'b1);
      end
      vld[d] = 1'b0;
      wait_frames(d, base + 5);
      for (int i = 0; i < 5; i++) begin
        check("rnd_frame", 32'(fr[d][base + i]), 32'(model(smp[i])));
        check("rnd_active", 32'(hi[d][base + i]), 32'(32 * div_of(d)));
      end
      for (int i = 1; i < 5; i++) begin
        check("rnd_period", 32'(hsc[d][hb + i] - hsc[d][hb + i - 1]),
              32'(32 * div_of(d) + gap_of(d) + 1));
        check("rnd_gap", 32'(lo[d][lb + i]), 32'(gap_of(d) + 1));
      end
      repeat (5) @(posedge clk); #1;
    end

    // valid pulse and sample change while shifting are ignored
    base = nfr[0]; hsn = nhs[0];
    r = 16'($urandom);
    hs(0, r, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    sin[0] = 16'h1234; vld[0] = 1'b1;
    check("busy_ready", 32'(m_rdy[0]), 32'd0);
    @(posedge clk); #1;
    check("busy_ready2", 32'(m_rdy[0]), 32'd0);
    vld[0] = 1'b0; sin[0] = ~r;
    wait_frames(0, base + 1);
    check("busy_frame", 32'(fr[0][base]), 32'(model(r)));
    check("busy_hs_count", 32'(nhs[0] - hsn), 32'd1);
    repeat (5) @(posedge clk); #1;

    // reset during bit 7 aborts the frame
    base = nfr[0]; dc = done_cnt[0]; ab = aborts[0];
    r = 16'($urandom);
    hs(0, r, 1'b0);
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk); #1;
      if (cur_n[0] >= 9) hit = 1'b1;
    end
    check("bit7_reached", 32'(hit), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs(0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_abort", 32'(m_rdy[0]), 32'd1);
    repeat (3) @(posedge clk); #1;
    check("abort_seen", 32'(aborts[0] - ab), 32'd1);
    check("abort_no_done", 32'(done_cnt[0] - dc), 32'd0);
    check("abort_no_frame", 32'(nfr[0] - base), 32'd0);
    r = 16'($urandom);
    hs(0, r, 1'b0);
    wait_frames(0, base + 1);
    check("post_abort_frame", 32'(fr[0][base]), 32'(model(r)));
    check("post_abort_bits", 32'(nb[0][base]), 32'd16);
    repeat (5) @(posedge clk); #1;

    // whole-run wire rules
    for (int d = 0; d < 2; d++) begin
      check("mosi_stable", 32'(stab_err[d]), 32'd0);
      check("sclk_idle_low", 32'(idle_err[d]), 32'd0);
      check("done_at_end", 32'(done_err[d]), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial transmitter for the audio DAC path. It accepts 16-bit processed audio samples from the effect chain through a valid/ready handshake and reduces each one to 12 bits. It prepends 4 DAC configuration bits and shifts the resulting 16-bit frame out MSB-first over a mode-0 SPI link (`sclk_out`, `mosi_out`, `active_out`). It is the transmitting end of the same framing the DAC-side receiver consumes: 16 bits per frame, sampled on the rising SCLK edge, while `active_out` is high.

## Interface
- `CLK_DIV`, default 2: system cycles per SCLK half-period; legal range ≥1. SCLK frequency = 25 MHz / (2·`CLK_DIV`).
- `CFG_BITS`, default 4'b0011: frame bits [15:12] (channel A, unbuffered, gain 1x, output active).
- `GAP_CYCLES`, default 2: minimum cycles `active_out` stays low between frames; legal range ≥1.
- `clk_25mhz` input, 1 bit: system clock. One clock domain only.
- `reset` input, 1 bit: synchronous, active-high reset.
- `sample_in` input, 16 bits: signed audio sample. Only `[15:4]` is transmitted.
- `sample_valid` input, 1 bit: `sample_in` is valid.
- `sample_ready` output, 1 bit: block can accept a sample this cycle.
- `sclk_out` output, 1 bit: SPI clock, idle low.
- `mosi_out` output, 1 bit: serial data, MSB first.
- `active_out` output, 1 bit: frame enable, high for the whole frame (board inverts it for the DAC CS).
- `frame_done` output, 1 bit: one-cycle pulse when a frame completes.

## Operation
- Frame: `{CFG_BITS, sample_in[15:4]}`, captured in full at the handshake. Truncation only; no rounding or saturation.
- States:
  - IDLE: `sample_ready`=1. On `sample_valid && sample_ready`, load the shift register and go to SHIFT.
  - SHIFT: `active_out`=1. Bits are sent with bit counter 15→0. After the high phase of bit 0 completes, go to GAP.
  - GAP: `active_out`=0, `sclk_out`=0. Hold for `GAP_CYCLES`, then go to IDLE.
- Per bit in SHIFT:
  - Low phase: `mosi_out` holds the current bit and `sclk_out`=0 for `CLK_DIV` cycles.
  - High phase: `sclk_out`=1 for `CLK_DIV` cycles.
  - The next bit is presented on the same edge that drives `sclk_out` low.
- `sample_valid` outside IDLE is ignored; there is no buffering. The upstream source must hold the sample until the handshake.
- `sample_in` changing after capture has no effect on the frame in flight.
- `sample_ready` goes low on the edge that accepts a sample.

## Timing
- Reset values, one edge after `reset`=1: state IDLE, `sample_ready`=0, `sclk_out`=0, `mosi_out`=0, `active_out`=0, `frame_done`=0, all counters 0.
- `sample_ready` rises on the first edge after `reset` deasserts.
- Reset mid-frame: the frame is aborted at that edge, with no partial completion and no `frame_done`.
- Handshake at edge T:
  - T+1: `active_out`=1 and `mosi_out` = frame[15].
  - First SCLK rising edge at T+1+`CLK_DIV`.
  - Frame length is exactly 32·`CLK_DIV` cycles of `active_out`=1.
- End of frame at edge E (end of bit 0 high phase):
  - `active_out`=0, `sclk_out`=0, `mosi_out`=0.
  - `frame_done`=1 for exactly one cycle.
  - `sample_ready`=1 at E+`GAP_CYCLES`.
- Sample-to-sample period with a continuously valid source: 32·`CLK_DIV` + `GAP_CYCLES` + 1 cycles. This is 67 cycles at the defaults.
- `mosi_out` is stable for the entire SCLK high phase and changes only when `sclk_out` goes low.
- `CLK_DIV`=1 gives SCLK = clk/2 with 50 % duty; it must work without special casing.

## Structure
- Shared package `dac_pkg`:
  - State enum `dac_tx_state_t` (IDLE, SHIFT, GAP).
  - `FRAME_BITS`=16, `DAC_DATA_BITS`=12, `DAC_CFG_DEFAULT`=4'b0011.
- One sub-module, `sclk_divider`: phase counter of width `$clog2(CLK_DIV)`, minimum 1 bit. It produces one-cycle `rise_en` and `fall_en` strobes, is enabled only in SHIFT, and clears when not in SHIFT.
- The top level holds the FSM, the 16-bit shift register, the 4-bit bit counter, and the gap counter.

## Test plan
- Defaults, `sample_in`=16'hABCD:
  - Frame is 16'h3ABC; `mosi_out` sampled on 16 SCLK rises = 0011_1010_1011_1100.
  - `active_out` high for 64 cycles; one `frame_done` pulse.
- `sample_in`=16'hFFFF then 16'h000F, `sample_valid` held high:
  - Frames are 16'h3FFF then 16'h3000.
  - `active_out` low for exactly 3 cycles between frames; period 67 cycles.
- `CLK_DIV`=1, `sample_in`=16'h8000:
  - `sclk_out` toggles every cycle; frame is 16'h3800.
  - `active_out` high for 32 cycles.
- `sample_valid` pulsed with 16'h1234 during SHIFT, and `sample_in` changed mid-frame:
  - Neither is accepted or transmitted.
  - The in-flight frame is unchanged and `sample_ready` stays 0.
- `reset` asserted for 1 cycle at bit 7 of a frame:
  - Next edge: all outputs at reset values and no `frame_done`.
  - `sample_ready`=1 one cycle after release; the next frame starts clean from bit 15.
